// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// Pipeline register between EX and MEM. It is built as a two-entry skid buffer:
// an output register that drives o_mem_* and a skid register behind it.
// Because o_ex_ready comes straight from a flop, the EX stage never sees a
// combinational path from i_mem_ready. Branch outcomes are resolved when an
// entry is accepted, and a taken branch raises a one-cycle redirect pulse.
//
// Ports:
//   i_clk, i_rst_n         clock; asynchronous active-low reset
//   i_ex_valid/o_ex_ready  upstream handshake
//   i_alu_result, i_flags, i_store_data, i_rd_addr, i_rd_wren, i_mem_wren,
//   i_mem_rden, i_is_branch, i_funct3, i_pc_target   EX payload
//   i_flush                squash held and incoming entries
//   o_mem_valid/i_mem_ready downstream handshake
//   o_mem_result, o_mem_store_data, o_mem_rd_addr, o_mem_rd_wren,
//   o_mem_wren, o_mem_rden MEM payload
//   o_redirect, o_redirect_pc  taken-branch pulse and its target
// ---------------------------------------------------------------------------
module ex_mem_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ex_valid,
  output logic        o_ex_ready,
  input  logic [31:0] i_alu_result,
  input  logic [3:0]  i_flags,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_wren,
  input  logic        i_mem_wren,
  input  logic        i_mem_rden,
  input  logic        i_is_branch,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_pc_target,
  input  logic        i_flush,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_result,
  output logic [31:0] o_mem_store_data,
  output logic [4:0]  o_mem_rd_addr,
  output logic        o_mem_rd_wren,
  output logic        o_mem_wren,
  output logic        o_mem_rden,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc
);

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic        mem_wren;
    logic        mem_rden;
  } entry_t;

  entry_t      w_in;
  entry_t      r_out;
  entry_t      r_skid;
  logic        r_out_valid;
  logic        r_skid_valid;
  logic        r_ex_ready;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;

  logic        w_accept;
  logic        w_xfer_out;
  logic        w_taken;
  logic        w_z, w_n, w_v, w_c;

  assign {w_z, w_n, w_v, w_c} = i_flags;

  // A write to x0 is dropped at capture, so MEM/WB never see it.
  always_comb begin
    w_in.result     = i_alu_result;
    w_in.store_data = i_store_data;
    w_in.rd_addr    = i_rd_addr;
    w_in.rd_wren    = i_rd_wren & (i_rd_addr != 5'd0);
    w_in.mem_wren   = i_mem_wren;
    w_in.mem_rden   = i_mem_rden;
  end

  // Branch condition from the flags of the compare subtraction.
  always_comb begin
    w_taken = 1'b0;
    case (i_funct3)
      3'b000:  w_taken = w_z;
      3'b001:  w_taken = ~w_z;
      3'b100:  w_taken = w_n ^ w_v;
      3'b101:  w_taken = ~(w_n ^ w_v);
      3'b110:  w_taken = ~w_c;
      3'b111:  w_taken = w_c;
      default: w_taken = 1'b0;
    endcase
  end

  // A flush cycle accepts nothing, so it also cannot raise a redirect.
  assign w_accept   = i_ex_valid & r_ex_ready & ~i_flush;
  assign w_xfer_out = r_out_valid & i_mem_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out         <= '0;
      r_skid        <= '0;
      r_out_valid   <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_ex_ready    <= 1'b1;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= w_accept & i_is_branch & w_taken;
      if (w_accept & i_is_branch & w_taken)
        r_redirect_pc <= i_pc_target;

      if (i_flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
        r_ex_ready   <= 1'b1;
      end else if (r_skid_valid) begin
        // r_ex_ready is low here, so the only possible event is a drain.
        if (w_xfer_out) begin
          r_out        <= r_skid;
          r_skid_valid <= 1'b0;
          r_ex_ready   <= 1'b1;
        end
      end else if (w_accept) begin
        if (!r_out_valid || w_xfer_out) begin
          r_out       <= w_in;
          r_out_valid <= 1'b1;
        end else begin
          // The output register is stalled, so park the new entry behind it.
          r_skid       <= w_in;
          r_skid_valid <= 1'b1;
          r_ex_ready   <= 1'b0;
        end
      end else if (w_xfer_out) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_ex_ready       = r_ex_ready;
  assign o_mem_valid      = r_out_valid;
  assign o_mem_result     = r_out.result;
  assign o_mem_store_data = r_out.store_data;
  assign o_mem_rd_addr    = r_out.rd_addr;
  assign o_mem_rd_wren    = r_out.rd_wren;
  assign o_mem_wren       = r_out.mem_wren;
  assign o_mem_rden       = r_out.mem_rden;
  assign o_redirect       = r_redirect;
  assign o_redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
// Self-checking bench for ex_mem_stage. The reference model treats the stage
// as an ordered queue that holds at most two entries. The stage is ready
// whenever fewer than two entries are held. The head of the queue is what MEM
// sees. A set of directed scenarios with literal expectations comes first,
// followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic [3:0]  flags;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        rd_wren, mem_wren, mem_rden, is_branch;
  logic [2:0]  funct3;
  logic [31:0] pc_target;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd_addr;
  logic        mem_rd_wren, mem_wren_o, mem_rden_o;
  logic        redirect;
  logic [31:0] redirect_pc;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ex_valid       (ex_valid),
    .o_ex_ready       (ex_ready),
    .i_alu_result     (alu_result),
    .i_flags          (flags),
    .i_store_data     (store_data),
    .i_rd_addr        (rd_addr),
    .i_rd_wren        (rd_wren),
    .i_mem_wren       (mem_wren),
    .i_mem_rden       (mem_rden),
    .i_is_branch      (is_branch),
    .i_funct3         (funct3),
    .i_pc_target      (pc_target),
    .i_flush          (flush),
    .o_mem_valid      (mem_valid),
    .i_mem_ready      (mem_ready),
    .o_mem_result     (mem_result),
    .o_mem_store_data (mem_store_data),
    .o_mem_rd_addr    (mem_rd_addr),
    .o_mem_rd_wren    (mem_rd_wren),
    .o_mem_wren       (mem_wren_o),
    .o_mem_rden       (mem_rden_o),
    .o_redirect       (redirect),
    .o_redirect_pc    (redirect_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic        mem_wren;
    logic        mem_rden;
  } tb_entry_t;

  tb_entry_t   mq[$];
  tb_entry_t   m_new;
  logic        m_redir    = 1'b0;
  logic [31:0] m_redir_pc = '0;
  logic        m_acc, m_xfer;

  // Flags are {Z,N,V,C}.
  function automatic logic spec_taken(input logic [2:0] f3, input logic [3:0] fl);
    case (f3)
      3'd0:    return fl[3];
      3'd1:    return !fl[3];
      3'd4:    return fl[2] != fl[1];
      3'd5:    return fl[2] == fl[1];
      3'd6:    return !fl[0];
      3'd7:    return fl[0];
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_redir    = 1'b0;
      m_redir_pc = '0;
    end else begin
      m_acc   = ex_valid && (mq.size() < 2) && !flush;
      m_xfer  = (mq.size() > 0) && mem_ready;
      m_redir = m_acc && is_branch && spec_taken(funct3, flags);
      if (m_redir) m_redir_pc = pc_target;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_xfer) void'(mq.pop_front());
        if (m_acc) begin
          m_new.result     = alu_result;
          m_new.store_data = store_data;
          m_new.rd_addr    = rd_addr;
          m_new.rd_wren    = rd_wren && (rd_addr != 0);
          m_new.mem_wren   = mem_wren;
          m_new.mem_rden   = mem_rden;
          mq.push_back(m_new);
        end
      end
    end
    #1;
    check("mdl_mem_valid", {31'd0, mem_valid}, {31'd0, mq.size() > 0});
    check("mdl_ex_ready", {31'd0, ex_ready}, {31'd0, mq.size() < 2});
    check("mdl_redirect", {31'd0, redirect}, {31'd0, m_redir});
    check("mdl_redirect_pc", redirect_pc, m_redir_pc);
    if (mq.size() > 0) begin
      check("mdl_result", mem_result, mq[0].result);
      check("mdl_store_data", mem_store_data, mq[0].store_data);
      check("mdl_ctrl", {24'd0, mem_rd_addr, mem_rd_wren, mem_wren_o, mem_rden_o},
            {24'd0, mq[0].rd_addr, mq[0].rd_wren, mq[0].mem_wren, mq[0].mem_rden});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic rdw, input logic br, input logic [2:0] f3,
                       input logic [3:0] fl, input logic [31:0] pc);
    ex_valid   = v;
    alu_result = res;
    store_data = ~res;
    rd_addr    = rd;
    rd_wren    = rdw;
    mem_wren   = 1'b0;
    mem_rden   = 1'b0;
    is_branch  = br;
    funct3     = f3;
    flags      = fl;
    pc_target  = pc;
    flush      = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    idle();

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_result", mem_result, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    rst_n = 1'b1;

    // Back-to-back stream, starting on the first edge after reset release
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, k, 5'd3, 1'b1, 1'b0, 3'd0, 4'd0, 32'd0);
      tick();
      check("stream_result", mem_result, k);
      check("stream_ex_ready", {31'd0, ex_ready}, 32'd1);
    end
    idle();
    tick();
    check("stream_drained", {31'd0, mem_valid}, 32'd0);

    // Backpressure: three entries arrive while MEM is stalled
    mem_ready = 1'b0;
    drive(1'b1, 32'd10, 5'd1, 1'b1, 1'b0, 3'd0, 4'd0, 32'd0);
    tick();
    check("bp_first_ready", {31'd0, ex_ready}, 32'd1);
    drive(1'b1, 32'd11, 5'd1, 1'b1, 1'b0, 3'd0, 4'd0, 32'd0);
    tick();
    check("bp_full_ready", {31'd0, ex_ready}, 32'd0);
    check("bp_hold_result", mem_result, 32'd10);
    drive(1'b1, 32'd12, 5'd1, 1'b1, 1'b0, 3'd0, 4'd0, 32'd0);
    tick();
    check("bp_stable_result", mem_result, 32'd10);
    mem_ready = 1'b1;
    tick();
    check("bp_rel_result2", mem_result, 32'd11);
    check("bp_rel_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    check("bp_rel_result3", mem_result, 32'd12);
    idle();
    tick();
    check("bp_empty", {31'd0, mem_valid}, 32'd0);

    // BLT taken: N=1, V=0
    drive(1'b1, 32'h77, 5'd0, 1'b0, 1'b1, 3'b100, 4'b0100, 32'h0000_0080);
    tick();
    check("blt_redirect", {31'd0, redirect}, 32'd1);
    check("blt_redirect_pc", redirect_pc, 32'h80);
    check("blt_passes_mem", {31'd0, mem_valid}, 32'd1);
    idle();
    tick();
    check("blt_pulse_end", {31'd0, redirect}, 32'd0);
    check("blt_pc_held", redirect_pc, 32'h80);
    // BGEU with C=0: not taken
    drive(1'b1, 32'h78, 5'd0, 1'b0, 1'b1, 3'b111, 4'b0000, 32'h0000_0100);
    tick();
    check("bgeu_no_redirect", {31'd0, redirect}, 32'd0);
    check("bgeu_pc_held", redirect_pc, 32'h80);

    // Write to x0 is dropped, write to x5 is kept
    drive(1'b1, 32'h99, 5'd0, 1'b1, 1'b0, 3'd0, 4'd0, 32'd0);
    tick();
    check("x0_rd_wren", {31'd0, mem_rd_wren}, 32'd0);
    drive(1'b1, 32'h9a, 5'd5, 1'b1, 1'b0, 3'd0, 4'd0, 32'd0);
    tick();
    check("x5_rd_wren", {31'd0, mem_rd_wren}, 32'd1);
    idle();
    tick();

    // Flush with both entries full and a taken branch at the input
    mem_ready = 1'b0;
    drive(1'b1, 32'd20, 5'd2, 1'b1, 1'b0, 3'd0, 4'd0, 32'd0);
    tick();
    drive(1'b1, 32'd21, 5'd2, 1'b1, 1'b0, 3'd0, 4'd0, 32'd0);
    tick();
    check("fl_full", {31'd0, ex_ready}, 32'd0);
    drive(1'b1, 32'd22, 5'd2, 1'b1, 1'b1, 3'b100, 4'b0100, 32'h0000_0200);
    flush = 1'b1;
    tick();
    check("fl_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("fl_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("fl_redirect", {31'd0, redirect}, 32'd0);
    // Flush while ready: the taken branch must still not redirect
    drive(1'b1, 32'd23, 5'd2, 1'b1, 1'b1, 3'b000, 4'b1000, 32'h0000_0300);
    flush = 1'b1;
    tick();
    check("fl2_redirect", {31'd0, redirect}, 32'd0);
    check("fl2_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("fl2_pc_held", redirect_pc, 32'h80);

    // Reset asserted with a held entry and a pending redirect
    drive(1'b1, 32'h55, 5'd4, 1'b1, 1'b1, 3'b100, 4'b0100, 32'h0000_0044);
    tick();
    check("ar_pre_valid", {31'd0, mem_valid}, 32'd1);
    check("ar_pre_redirect", {31'd0, redirect}, 32'd1);
    idle();
    rst_n = 1'b0;
    #1;
    check("ar_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("ar_result", mem_result, 32'd0);
    check("ar_redirect", {31'd0, redirect}, 32'd0);
    check("ar_redirect_pc", redirect_pc, 32'd0);
    check("ar_ex_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ex_valid   = ($urandom_range(0, 3) != 0);
      mem_ready  = ($urandom_range(0, 2) != 0);
      alu_result = $urandom;
      store_data = $urandom;
      rd_addr    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rd_wren    = 1'($urandom_range(0, 1));
      mem_wren   = 1'($urandom_range(0, 1));
      mem_rden   = 1'($urandom_range(0, 1));
      is_branch  = 1'($urandom_range(0, 1));
      funct3     = 3'($urandom_range(0, 7));
      flags      = 4'($urandom_range(0, 15));
      pc_target  = $urandom;
      flush      = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
    mem_ready = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
